// File: rtl/seg_scan_lut.sv
// Multiplexed seven-segment scan driver: shadows per-digit codes, swaps them in at frame
// start, and drives one registered, LUT-decoded digit per refresh slot.
module seg_scan_lut #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic [4*NUM_DIGITS-1:0] code_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    disp_en,
  output logic [NUM_DIGITS-1:0]   led_sel,
  output logic [7:0]              lut_out,
  output logic                    frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    frame_start;

  logic [4*NUM_DIGITS-1:0] sh_code;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [4*NUM_DIGITS-1:0] act_code;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [4*NUM_DIGITS-1:0] src_code;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [7:0]              seg_val;
  logic [NUM_DIGITS-1:0]   next_sel;
  logic [7:0]              next_lut;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    case (code)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign tick        = (presc == CNT_LAST);
  assign frame_start = tick && (idx == '0);

  always_ff @(posedge iclk) begin
    if (irst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      sh_code  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_code  <= code_in;
      sh_dp    <= dp_in;
      sh_blank <= blank_in;
    end
  end

  // Samples the shadow before this cycle's load, so a load on the frame-start tick waits a frame.
  always_ff @(posedge iclk) begin
    if (irst) begin
      act_code  <= '0;
      act_dp    <= '0;
      act_blank <= '0;
    end else if (frame_start) begin
      act_code  <= sh_code;
      act_dp    <= sh_dp;
      act_blank <= sh_blank;
    end
  end

  // Digit 0 of a new frame reads the shadow directly, since the active copy lands on this same edge.
  assign src_code  = frame_start ? sh_code  : act_code;
  assign src_dp    = frame_start ? sh_dp    : act_dp;
  assign src_blank = frame_start ? sh_blank : act_blank;

  always_comb begin
    cur_code   = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_code      = src_code[4*k +: 4];
        cur_dp        = src_dp[k];
        cur_blank     = src_blank[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  assign seg_val  = {cur_dp, hex_to_seg(cur_code)};
  assign next_sel = cur_blank ? SEL_OFF : (SEL_ACTIVE_LOW ? ~cur_onehot : cur_onehot);
  assign next_lut = cur_blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~seg_val : seg_val);

  // After disp_en returns, outputs stay dark until the next slot boundary to avoid a partial slot.
  always_ff @(posedge iclk) begin
    if (irst || !disp_en) begin
      led_sel    <= SEL_OFF;
      lut_out    <= SEG_OFF;
      frame_done <= 1'b0;
    end else if (tick) begin
      led_sel    <= next_sel;
      lut_out    <= next_lut;
      frame_done <= (idx == IDX_LAST);
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_lut.sv
// Bench for seg_scan_lut: three configurations share one stimulus stream and are checked
// every cycle against a slot/frame model, with literal pins on the directed scenarios.
module tb_seg_scan_lut;

  localparam int ND0 = 4, CD0 = 4;
  localparam int ND1 = 4, CD1 = 5;
  localparam int ND2 = 1, CD2 = 3;

  logic        clk = 1'b0;
  logic        irst = 1'b1;
  logic        load = 1'b0;
  logic        disp_en = 1'b1;
  logic [15:0] code_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [3:0]  sel0, sel1;
  logic        sel2;
  logic [7:0]  lut0, lut1, lut2;
  logic        fd0, fd1, fd2;

  logic [7:0]  act_sel [3];
  logic [7:0]  act_lut [3];
  logic [7:0]  act_fd  [3];

  int          n_checks = 0;
  int          n_fail = 0;
  int          tcyc = 0;
  int          u2_fd_count = 0;

  int          n_cnt [3];
  int          slot_m;
  logic [3:0]  fr_code  [3][4];
  logic        fr_dp    [3][4];
  logic        fr_blank [3][4];
  logic [7:0]  exp_sel [3];
  logic [7:0]  exp_lut [3];
  logic        exp_fd  [3];
  logic [15:0] last_code = '0;
  logic [3:0]  last_dp = '0;
  logic [3:0]  last_blank = '0;

  always #5 clk = ~clk;

  seg_scan_lut #(.NUM_DIGITS(ND0), .CLK_DIV(CD0), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u0 (
    .iclk(clk), .irst(irst), .code_in(code_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .disp_en(disp_en), .led_sel(sel0), .lut_out(lut0), .frame_done(fd0));

  seg_scan_lut #(.NUM_DIGITS(ND1), .CLK_DIV(CD1), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u1 (
    .iclk(clk), .irst(irst), .code_in(code_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .disp_en(disp_en), .led_sel(sel1), .lut_out(lut1), .frame_done(fd1));

  seg_scan_lut #(.NUM_DIGITS(ND2), .CLK_DIV(CD2), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u2 (
    .iclk(clk), .irst(irst), .code_in(code_in[3:0]), .dp_in(dp_in[0]), .blank_in(blank_in[0]),
    .load(load), .disp_en(disp_en), .led_sel(sel2), .lut_out(lut2), .frame_done(fd2));

  assign act_sel[0] = {4'b0, sel0};
  assign act_sel[1] = {4'b0, sel1};
  assign act_sel[2] = {7'b0, sel2};
  assign act_lut[0] = lut0;
  assign act_lut[1] = lut1;
  assign act_lut[2] = lut2;
  assign act_fd[0]  = {7'b0, fd0};
  assign act_fd[1]  = {7'b0, fd1};
  assign act_fd[2]  = {7'b0, fd2};

  function automatic int nd_of(input int i);
    return (i == 0) ? ND0 : (i == 1) ? ND1 : ND2;
  endfunction

  function automatic int cd_of(input int i);
    return (i == 0) ? CD0 : (i == 1) ? CD1 : CD2;
  endfunction

  function automatic bit low_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] sel_mask(input int i);
    return 8'((1 << nd_of(i)) - 1);
  endfunction

  function automatic logic [7:0] sel_off(input int i);
    return low_of(i) ? sel_mask(i) : 8'h00;
  endfunction

  function automatic logic [7:0] lut_off(input int i);
    return low_of(i) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] sel_on(input int i, input int slot);
    logic [7:0] oh;
    oh = 8'(1) << slot;
    return low_of(i) ? (~oh & sel_mask(i)) : oh;
  endfunction

  function automatic logic [7:0] lut_on(input int i, input logic [3:0] c, input logic dp);
    logic [7:0] seg;
    seg = {dp, seg7(c)};
    return low_of(i) ? ~seg : seg;
  endfunction

  // Edge n after reset release is a slot boundary when n is a multiple of the divider;
  // slot m shows digit (m-1) mod N, and digit 0 picks up the most recent earlier load.
  always @(posedge clk) begin
    tcyc++;
    for (int i = 0; i < 3; i++) begin
      if (irst) begin
        n_cnt[i] = 0;
        for (int k = 0; k < 4; k++) begin
          fr_code[i][k]  = 4'h0;
          fr_dp[i][k]    = 1'b0;
          fr_blank[i][k] = 1'b0;
        end
        exp_sel[i] = sel_off(i);
        exp_lut[i] = lut_off(i);
        exp_fd[i]  = 1'b0;
      end else begin
        n_cnt[i]++;
        exp_fd[i] = 1'b0;
        if (n_cnt[i] % cd_of(i) == 0) begin
          slot_m = (n_cnt[i] / cd_of(i) - 1) % nd_of(i);
          if (slot_m == 0) begin
            for (int k = 0; k < nd_of(i); k++) begin
              fr_code[i][k]  = last_code[4*k +: 4];
              fr_dp[i][k]    = last_dp[k];
              fr_blank[i][k] = last_blank[k];
            end
          end
          if (!disp_en || fr_blank[i][slot_m]) begin
            exp_sel[i] = sel_off(i);
            exp_lut[i] = lut_off(i);
          end else begin
            exp_sel[i] = sel_on(i, slot_m);
            exp_lut[i] = lut_on(i, fr_code[i][slot_m], fr_dp[i][slot_m]);
          end
          exp_fd[i] = disp_en && (slot_m == nd_of(i) - 1);
        end else if (!disp_en) begin
          exp_sel[i] = sel_off(i);
          exp_lut[i] = lut_off(i);
        end
      end
    end
    if (irst) begin
      last_code  = '0;
      last_dp    = '0;
      last_blank = '0;
    end else if (load) begin
      last_code  = code_in;
      last_dp    = dp_in;
      last_blank = blank_in;
    end
  end

  task automatic check_output(input string tag, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", tag, tcyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (tcyc >= 1) begin
      for (int i = 0; i < 3; i++) begin
        check_output($sformatf("model u%0d led_sel", i), act_sel[i], exp_sel[i]);
        check_output($sformatf("model u%0d lut_out", i), act_lut[i], exp_lut[i]);
        check_output($sformatf("model u%0d frame_done", i), act_fd[i], {7'b0, exp_fd[i]});
      end
      if (tcyc >= 20 && tcyc <= 49 && fd2) u2_fd_count++;
    end
  end

  task automatic at_edge(input int k);
    while (tcyc < k) @(negedge clk);
  endtask

  task automatic pin(input int k, input int inst, input logic [7:0] sel,
                     input logic [7:0] lut, input logic fd);
    at_edge(k);
    check_output($sformatf("pin u%0d led_sel @%0d", inst, k), act_sel[inst], sel);
    check_output($sformatf("pin u%0d lut_out @%0d", inst, k), act_lut[inst], lut);
    check_output($sformatf("pin u%0d frame_done @%0d", inst, k), act_fd[inst], {7'b0, fd});
  endtask

  task automatic apply_stimulus(input logic ld, input logic [15:0] c, input logic [3:0] dp,
                                input logic [3:0] bl);
    load     = ld;
    code_in  = c;
    dp_in    = dp;
    blank_in = bl;
  endtask

  initial begin
    $display("[TB] start");
    pin(3, 0, 8'h0F, 8'hFF, 1'b0);
    irst = 1'b0;
    apply_stimulus(1'b1, 16'h3210, 4'b0000, 4'b0000);
    at_edge(4);
    load = 1'b0;
    pin(6, 0, 8'h0F, 8'hFF, 1'b0);
    pin(7, 0, 8'h0E, 8'hC0, 1'b0);
    pin(23, 0, 8'h0E, 8'hC0, 1'b0);
    pin(27, 0, 8'h0D, 8'hF9, 1'b0);
    pin(31, 0, 8'h0B, 8'hA4, 1'b0);
    pin(35, 0, 8'h07, 8'hB0, 1'b1);
    pin(36, 0, 8'h07, 8'hB0, 1'b0);

    at_edge(44);
    apply_stimulus(1'b1, 16'hFEDC, 4'b0000, 4'b0000);
    at_edge(45);
    load = 1'b0;
    pin(47, 0, 8'h0B, 8'hA4, 1'b0);
    at_edge(50);
    check_output("u2 frame_done pulses in 30 cycles", 8'(u2_fd_count), 8'd10);
    pin(51, 0, 8'h07, 8'hB0, 1'b1);
    pin(55, 0, 8'h0E, 8'hC6, 1'b0);

    at_edge(56);
    apply_stimulus(1'b1, 16'hFEDC, 4'b0000, 4'b0100);
    at_edge(57);
    load = 1'b0;
    pin(59, 0, 8'h0D, 8'hA1, 1'b0);
    pin(63, 0, 8'h0B, 8'h86, 1'b0);
    pin(67, 0, 8'h07, 8'h8E, 1'b1);
    pin(71, 0, 8'h0E, 8'hC6, 1'b0);
    pin(79, 0, 8'h0F, 8'hFF, 1'b0);
    pin(82, 0, 8'h0F, 8'hFF, 1'b0);
    pin(83, 0, 8'h07, 8'h8E, 1'b1);

    at_edge(84);
    apply_stimulus(1'b1, 16'h0008, 4'b0001, 4'b0000);
    at_edge(85);
    load = 1'b0;
    pin(87, 0, 8'h0E, 8'h00, 1'b0);
    pin(88, 1, 8'h01, 8'hFF, 1'b0);
    at_edge(89);
    disp_en = 1'b0;
    pin(90, 1, 8'h00, 8'h00, 1'b0);
    pin(90, 0, 8'h0F, 8'hFF, 1'b0);
    at_edge(95);
    disp_en = 1'b1;
    pin(97, 1, 8'h00, 8'h00, 1'b0);
    pin(98, 1, 8'h04, 8'h3F, 1'b0);
    pin(99, 0, 8'h07, 8'hC0, 1'b1);

    at_edge(112);
    irst = 1'b1;
    pin(113, 0, 8'h0F, 8'hFF, 1'b0);
    irst = 1'b0;
    pin(116, 0, 8'h0F, 8'hFF, 1'b0);
    pin(117, 0, 8'h0E, 8'hC0, 1'b0);

    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      apply_stimulus($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom),
                     4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 24) == 0) disp_en = ~disp_en;
      irst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    irst = 1'b0;
    load = 1'b0;
    disp_en = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
